x_vector_line_cache: RTL and testbench

Parametrised direct-mapped line cache for the x vector in the SpMV processing element. Sits between the column-index stream and the memory request/response port. Converts each pushed column index into a 64-bit x value, delivered in push order. Misses fetch a whole line of `LINE_WORDS` consecutive words, so neighbouring columns hit without extra memory traffic.

---
 rtl/x_cache_pkg.sv | 20 ++
 rtl/col_fifo.sv | 40 ++++
 rtl/x_vector_line_cache.sv | 139 +++++++++++++
 tb/tb_x_vector_line_cache.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/x_cache_pkg.sv
// Shared types and field-width helpers for the x-vector line cache.
package x_cache_pkg;
  localparam int ADDR_W = 48;
  localparam int WORD_W = 64;
  localparam int COL_W  = 32;

  typedef enum logic [1:0] {IDLE, LOOKUP, REQ, FILL} state_e;

  function automatic int ofs_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int tag_w(input int line_words, input int depth);
    return COL_W - ofs_w(line_words) - idx_w(depth);
  endfunction
endpackage

// File: rtl/col_fifo.sv
// Synchronous FIFO for the column stream; registered almost_full from next-state count.
module col_fifo #(
  parameter int W         = 32,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 4,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          almost_full
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;
  logic [AW:0]   cnt_nxt;

  assign do_pop  = pop && (count != '0);
  // a push into a full queue is accepted only when a pop frees a slot this cycle
  assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);
  assign cnt_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0; rp <= '0; count <= '0; almost_full <= 1'b0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      count       <= cnt_nxt;
      almost_full <= (DEPTH - int'(cnt_nxt)) <= AF_MARGIN;
    end

  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/x_vector_line_cache.sv
// Blocking direct-mapped line cache turning column indices into x values, in order.
// Optional hit/miss counters: define X_VECTOR_CACHE_STATS_EN.
module x_vector_line_cache
  import x_cache_pkg::*;
#(
  parameter int LINE_WORDS     = 4,
  parameter int DEPTH          = 16,
  parameter int COL_FIFO_DEPTH = 16,
  parameter int AF_MARGIN      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COL_W-1:0]  col,
  input  logic              push_col,
  input  logic [ADDR_W-1:0] start_address,
  input  logic              flush,
  output logic              req_mem,
  output logic [ADDR_W-1:0] req_mem_addr,
  input  logic              rsp_mem_push,
  input  logic [WORD_W-1:0] rsp_mem_q,
  output logic              push_x,
  output logic [WORD_W-1:0] x_val,
  input  logic              stall,
  output logic              almost_full
`ifdef X_VECTOR_CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);
  localparam int OFS = ofs_w(LINE_WORDS);
  localparam int IW  = idx_w(DEPTH);
  localparam int TW  = tag_w(LINE_WORDS, DEPTH);
  localparam int CW  = (OFS == 0) ? 1 : OFS;
  localparam int QW  = $clog2(COL_FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

  state_e                                state;
  logic [DEPTH-1:0]                      valid;
  logic [DEPTH-1:0][TW-1:0]              tag_mem;
  logic [DEPTH-1:0][LINE_WORDS-1:0][WORD_W-1:0] data_mem;

  logic [COL_W-1:0] head_col, base_col;
  logic [QW:0]      q_count;
  logic [CW-1:0]    h_off, req_cnt, fill_cnt;
  logic [IW-1:0]    h_idx, fill_idx;
  logic [TW-1:0]    h_tag;
  logic             hit, pop, in_fill, fill_we, fill_done, flush_pend;

  col_fifo #(.W(COL_W), .DEPTH(COL_FIFO_DEPTH), .AF_MARGIN(AF_MARGIN)) u_col_fifo (
    .clk(clk), .rst(rst), .push(push_col), .din(col), .pop(pop),
    .dout(head_col), .count(q_count), .almost_full(almost_full)
  );

  generate
    if (OFS > 0) begin : g_ofs
      assign h_off = head_col[CW-1:0];
    end else begin : g_no_ofs
      assign h_off = '0;
    end
  endgenerate
  assign h_idx = head_col[OFS +: IW];
  assign h_tag = head_col[OFS+IW +: TW];

  assign hit       = valid[h_idx] && (tag_mem[h_idx] == h_tag);
  assign pop       = (state == LOOKUP) && hit && !stall;
  assign in_fill   = (state == REQ) || (state == FILL);
  assign fill_we   = in_fill && rsp_mem_push;
  assign fill_done = (state == FILL) && rsp_mem_push && (fill_cnt == LAST);

  // Tag is written at miss time; the line stays invalid until its fill completes.
  always_ff @(posedge clk) begin
    if (fill_we) data_mem[fill_idx][fill_cnt] <= rsp_mem_q;
    if ((state == LOOKUP) && !hit) tag_mem[h_idx] <= h_tag;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE; valid <= '0; flush_pend <= 1'b0;
      req_mem <= 1'b0; req_mem_addr <= '0; push_x <= 1'b0; x_val <= '0;
      req_cnt <= '0; fill_cnt <= '0; fill_idx <= '0; base_col <= '0;
    end else begin
      req_mem <= 1'b0;
      push_x  <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) valid <= '0;
          if (q_count != '0) state <= LOOKUP;
        end
        LOOKUP: begin
          if (hit) begin
            if (!stall) begin
              push_x <= 1'b1;
              x_val  <= data_mem[h_idx][h_off];
              state  <= IDLE;
            end
          end else begin
            valid[h_idx] <= 1'b0;
            base_col     <= head_col & ~COL_W'(LINE_WORDS - 1);
            fill_idx     <= h_idx;
            req_cnt      <= '0;
            fill_cnt     <= '0;
            state        <= REQ;
          end
          if (flush) valid <= '0;
        end
        REQ: begin
          req_mem      <= 1'b1;
          req_mem_addr <= start_address + (ADDR_W'(base_col | COL_W'(req_cnt)) << 3);
          req_cnt      <= req_cnt + 1'b1;
          if (req_cnt == LAST) state <= FILL;
        end
        default: ;
      endcase
      if (in_fill && flush) flush_pend <= 1'b1;
      if (fill_we) fill_cnt <= fill_cnt + 1'b1;
      // a flush seen during the fill discards everything, including the new line
      if (fill_done) begin
        if (flush_pend || flush) valid <= '0;
        else                     valid[fill_idx] <= 1'b1;
        flush_pend <= 1'b0;
        state      <= LOOKUP;
      end
    end

`ifdef X_VECTOR_CACHE_STATS_EN
  logic hit_seen;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hit_count <= '0; miss_count <= '0; hit_seen <= 1'b0;
    end else if (state == LOOKUP) begin
      if (hit && !hit_seen && (hit_count != '1)) hit_count <= hit_count + 1'b1;
      if (!hit && (miss_count != '1))            miss_count <= miss_count + 1'b1;
      hit_seen <= hit && stall;
    end else begin
      hit_seen <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_x_vector_line_cache.sv
// Directed bench for x_vector_line_cache with a fixed-latency in-order memory model.
module tb_x_vector_line_cache;
  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] col = '0;
  logic        push_col = 1'b0, flush = 1'b0, stall = 1'b0;
  logic [47:0] start_address = '0;
  logic        req_mem, push_x, almost_full;
  logic [47:0] req_mem_addr;
  logic        rsp_mem_push;
  logic [63:0] rsp_mem_q, x_val;

  always #5 clk = ~clk;

  x_vector_line_cache #(.LINE_WORDS(4), .DEPTH(16), .COL_FIFO_DEPTH(16), .AF_MARGIN(4)) dut (
    .clk(clk), .rst(rst), .col(col), .push_col(push_col), .start_address(start_address),
    .flush(flush), .req_mem(req_mem), .req_mem_addr(req_mem_addr),
    .rsp_mem_push(rsp_mem_push), .rsp_mem_q(rsp_mem_q), .push_x(push_x), .x_val(x_val),
    .stall(stall), .almost_full(almost_full)
  );

  logic [47:0] reqs[$];
  logic [63:0] xq[$];
  logic [47:0] mq[$];
  int          mt[$];
  int          cyc = 0;
  int          nvec = 0, nerr = 0;

  // Monitor plus memory: word at byte address a holds a/8; 3-cycle latency, in order.
  initial begin
    rsp_mem_push = 1'b0;
    rsp_mem_q    = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (push_x) xq.push_back(x_val);
      if (req_mem) begin
        reqs.push_back(req_mem_addr);
        mq.push_back(req_mem_addr);
        mt.push_back(cyc);
      end
      rsp_mem_push = 1'b0;
      if (mq.size() > 0 && cyc - mt[0] >= 3) begin
        rsp_mem_push = 1'b1;
        rsp_mem_q    = 64'(mq[0] >> 3);
        void'(mq.pop_front());
        void'(mt.pop_front());
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [31:0] c);
    @(negedge clk); col = c; push_col = 1'b1;
    @(negedge clk); push_col = 1'b0;
  endtask

  task automatic wait_x(input int n);
    int k = 0;
    while (xq.size() < n && k < 300) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    chk("x_count", xq.size(), n);
  endtask

  task automatic clear_logs();
    xq.delete();
    reqs.delete();
  endtask

  int bad;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("reset_idle", {req_mem, push_x, almost_full, req_mem_addr, x_val}, '0);
    end

    // first miss fetches the whole line 0
    push1(0);
    wait_x(1);
    chk("miss0_nreq", reqs.size(), 4);
    for (int i = 0; i < 4; i++) chk("miss0_addr", reqs[i], 48'(i * 8));
    chk("miss0_x", xq[0], 0);
    clear_logs();

    // back-to-back hits, with hit latency on the first one
    @(negedge clk); col = 1; push_col = 1'b1;
    @(negedge clk); col = 3;
    chk("lat_n0", push_x, 0);
    @(negedge clk); col = 2;
    chk("lat_n1", push_x, 0);
    @(negedge clk); push_col = 1'b0;
    chk("lat_n2", {push_x, x_val}, {1'b1, 64'd1});
    wait_x(3);
    chk("hit_x0", xq[0], 1);
    chk("hit_x1", xq[1], 3);
    chk("hit_x2", xq[2], 2);
    chk("hit_nreq", reqs.size(), 0);
    clear_logs();

    // flush while idle, then conflict misses on index 0
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    push1(0);
    wait_x(1);
    chk("cf0_nreq", reqs.size(), 4);
    chk("cf0_x", xq[0], 0);
    clear_logs();
    push1(64);
    wait_x(1);
    chk("cf64_nreq", reqs.size(), 4);
    chk("cf64_addr0", reqs[0], 512);
    chk("cf64_addr3", reqs[3], 536);
    chk("cf64_x", xq[0], 64);
    clear_logs();
    push1(0);
    wait_x(1);
    chk("evict_nreq", reqs.size(), 4);
    chk("evict_x", xq[0], 0);
    clear_logs();

    // stalled hit is held, then released exactly once
    stall = 1'b1;
    push1(1);
    repeat (10) @(negedge clk);
    chk("stall_nx", xq.size(), 0);
    chk("stall_px", push_x, 0);
    stall = 1'b0;
    repeat (6) @(negedge clk);
    chk("unstall_nx", xq.size(), 1);
    chk("unstall_x", xq[0], 1);
    clear_logs();

    // fill the queue under stall to reach almost_full
    stall = 1'b1;
    @(negedge clk); col = 2; push_col = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      if (i == 13) push_col = 1'b0;
      if (i == 11) chk("af_11", almost_full, 0);
    end
    chk("af_13", almost_full, 1);
    chk("af_nx", xq.size(), 0);
    stall = 1'b0;
    wait_x(13);
    bad = 0;
    foreach (xq[i]) if (xq[i] !== 64'd2) bad++;
    chk("drain_vals", bad, 0);
    chk("af_drained", almost_full, 0);
    clear_logs();

    // flush raised during FILL invalidates the filled line and everything else
    push1(4);
    begin
      int k = 0;
      while (reqs.size() < 4 && k < 100) begin @(negedge clk); k++; end
    end
    chk("ff_in_fill", reqs.size(), 4);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    wait_x(1);
    chk("ff_nreq", reqs.size(), 8);
    chk("ff_refetch", reqs[4], 32);
    chk("ff_x", xq[0], 4);
    clear_logs();
    push1(0);
    wait_x(1);
    chk("ff_col0_nreq", reqs.size(), 4);
    chk("ff_col0_x", xq[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
